// File: rtl/arashi_pkg.sv
// Shared op encodings for the arashi ingress path.
// The ARASHI_INGRESS_STAT_EN option lives in arashi_ingress and does not affect this package.
package arashi_pkg;

    typedef logic [1:0] arashi_op_t;

    localparam arashi_op_t CTRL_IDLE = 2'b00;
    localparam arashi_op_t CTRL_RD   = 2'b01;
    localparam arashi_op_t CTRL_WR   = 2'b10;

    // A combined read+write request is stored as a plain write.
    function automatic arashi_op_t normalize_op(input arashi_op_t op);
        return op[1] ? CTRL_WR : op;
    endfunction

endpackage

// File: rtl/arashi_ingress_fifo.sv
// Single-thread synchronous FIFO holding {op, data}.
// The caller never pushes into a full FIFO and never pops an empty one.
module arashi_ingress_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/arashi_ingress.sv
// Per-thread request buffer feeding arashi_top with round-robin write capping.
// Define ARASHI_INGRESS_STAT_EN to add per-thread saturating stall counters (stall_cnt port).
module arashi_ingress
    import arashi_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int THREAD_NUM   = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int WR_PER_CYCLE = 2
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [THREAD_NUM-1:0]            req_valid,
    output logic [THREAD_NUM-1:0]            req_ready,
    input  logic [2*THREAD_NUM-1:0]          req_op,
    input  logic [DATA_WIDTH*THREAD_NUM-1:0] req_data,
    output logic [2*THREAD_NUM-1:0]          ctrl,
    output logic [DATA_WIDTH*THREAD_NUM-1:0] wdata
`ifdef ARASHI_INGRESS_STAT_EN
    ,
    output logic [16*THREAD_NUM-1:0]         stall_cnt
`endif
);

    localparam int PW = $clog2(THREAD_NUM);

    // Handshake: a request transfers on a clock edge where req_valid & req_ready are both high;
    // req_ready depends only on FIFO occupancy, never on the same-cycle pop.
    logic [THREAD_NUM-1:0]  full, empty, push, pop;
    arashi_op_t             head_op   [THREAD_NUM];
    logic [DATA_WIDTH-1:0]  head_data [THREAD_NUM];
    logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [2*THREAD_NUM-1:0]          ctrl_q, ctrl_d;
    logic [DATA_WIDTH*THREAD_NUM-1:0] wdata_q, wdata_d;

    assign req_ready = ~full & {THREAD_NUM{rstn}};

    for (genvar t = 0; t < THREAD_NUM; t++) begin : g_thread
        // Idle ops are acknowledged but never stored.
        assign push[t] = req_valid[t] & req_ready[t] & (req_op[2*t +: 2] != CTRL_IDLE);

        arashi_ingress_fifo #(
            .WIDTH (2 + DATA_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rstn  (rstn),
            .push  (push[t]),
            .din   ({normalize_op(req_op[2*t +: 2]), req_data[DATA_WIDTH*t +: DATA_WIDTH]}),
            .pop   (pop[t]),
            .dout  ({head_op[t], head_data[t]}),
            .empty (empty[t]),
            .full  (full[t])
        );
    end

    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        int            wr_cnt;
        pop      = '0;
        rr_ptr_d = rr_ptr_q;
        wr_cnt   = 0;
        sum      = '0;
        idx      = '0;
        for (int t = 0; t < THREAD_NUM; t++) begin
            if (!empty[t] && head_op[t] == CTRL_RD) begin
                pop[t] = 1'b1;
            end
        end
        // Scan writes starting at rr_ptr with wrap-around; the pointer follows the last grant.
        for (int i = 0; i < THREAD_NUM; i++) begin
            sum = {1'b0, rr_ptr_q} + (PW+1)'(i);
            if (sum >= (PW+1)'(THREAD_NUM)) begin
                sum = sum - (PW+1)'(THREAD_NUM);
            end
            idx = sum[PW-1:0];
            if (!empty[idx] && head_op[idx] == CTRL_WR && wr_cnt < WR_PER_CYCLE) begin
                pop[idx] = 1'b1;
                wr_cnt   = wr_cnt + 1;
                rr_ptr_d = (idx == PW'(THREAD_NUM - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

    always_comb begin
        ctrl_d  = '0;
        wdata_d = wdata_q;
        for (int t = 0; t < THREAD_NUM; t++) begin
            if (pop[t]) begin
                ctrl_d[2*t +: 2]                   = head_op[t];
                wdata_d[DATA_WIDTH*t +: DATA_WIDTH] = head_data[t];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr_q <= '0;
            ctrl_q   <= '0;
            wdata_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            ctrl_q   <= ctrl_d;
            wdata_q  <= wdata_d;
        end
    end

    assign ctrl  = ctrl_q;
    assign wdata = wdata_q;

`ifdef ARASHI_INGRESS_STAT_EN
    logic [16*THREAD_NUM-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        for (int t = 0; t < THREAD_NUM; t++) begin
            if (req_valid[t] && !req_ready[t] && stall_q[16*t +: 16] != 16'hFFFF) begin
                stall_d[16*t +: 16] = stall_q[16*t +: 16] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_arashi_ingress.sv
// Directed bench for arashi_ingress (THREAD_NUM=4, FIFO_DEPTH=4, WR_PER_CYCLE=2).
// Stall-counter checks are compiled in only with ARASHI_INGRESS_STAT_EN.
module tb_arashi_ingress;

    logic         clk;
    logic         rstn;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [7:0]   req_op;
    logic [127:0] req_data;
    logic [7:0]   ctrl;
    logic [127:0] wdata;
`ifdef ARASHI_INGRESS_STAT_EN
    logic [63:0]  stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    arashi_ingress #(
        .DATA_WIDTH   (32),
        .THREAD_NUM   (4),
        .FIFO_DEPTH   (4),
        .WR_PER_CYCLE (2)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .ctrl      (ctrl),
        .wdata     (wdata)
`ifdef ARASHI_INGRESS_STAT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        req_valid = '0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rstn      = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_data  = '0;

        // Reset and release
        tick();
        tick();
        check("rst_ready", 128'(req_ready), 128'h0);
        check("rst_ctrl", 128'(ctrl), 128'h0);
        check("rst_wdata", wdata, 128'h0);
        rstn = 1'b1;
        #1;
        check("rel_ready", 128'(req_ready), 128'hF);
        check("rel_ctrl", 128'(ctrl), 128'h0);

        // Single write on thread 1
        req_valid          = 4'b0010;
        req_op             = 8'b00_00_10_00;
        req_data[63:32]    = 32'hA5A5_0001;
        tick();
        req_valid = '0;
        check("sw_n1_ctrl", 128'(ctrl), 128'h0);
        tick();
        check("sw_n2_ctrl", 128'(ctrl), 128'h08);
        check("sw_n2_wdata", 128'(wdata[63:32]), 128'hA5A5_0001);
        tick();
        check("sw_n3_ctrl", 128'(ctrl), 128'h0);

        // Four writes in one cycle from rr_ptr=0
        do_reset();
        req_valid = 4'b1111;
        req_op    = 8'b10_10_10_10;
        req_data  = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
        tick();
        req_valid = '0;
        check("w4_push_ctrl", 128'(ctrl), 128'h0);
        tick();
        check("w4_c1_ctrl", 128'(ctrl), 128'h0A);
        check("w4_c1_wdata", 128'(wdata[63:0]), 128'h1000_0001_1000_0000);
        tick();
        check("w4_c2_ctrl", 128'(ctrl), 128'hA0);
        check("w4_c2_wdata", 128'(wdata[127:64]), 128'h1000_0003_1000_0002);
        tick();
        check("w4_c3_ctrl", 128'(ctrl), 128'h0);

        // Mixed: threads 0,2 read, threads 1,3 write
        req_valid = 4'b1111;
        req_op    = 8'b10_01_10_01;
        req_data  = {32'h2000_0003, 32'h0, 32'h2000_0001, 32'h0};
        tick();
        req_valid = '0;
        tick();
        check("mix_ctrl", 128'(ctrl), 128'h99);
        check("mix_wdata1", 128'(wdata[63:32]), 128'h2000_0001);
        check("mix_wdata3", 128'(wdata[127:96]), 128'h2000_0003);
        tick();
        check("mix_idle", 128'(ctrl), 128'h0);

        // op 00 is accepted and dropped
        req_valid = 4'b0100;
        req_op    = 8'b00_00_00_00;
        check("op00_ready", 128'(req_ready), 128'hF);
        tick();
        req_valid = '0;
        tick();
        check("op00_c1", 128'(ctrl), 128'h0);
        tick();
        check("op00_c2", 128'(ctrl), 128'h0);

        // op 11 is issued as a write
        req_valid        = 4'b1000;
        req_op           = 8'b11_00_00_00;
        req_data[127:96] = 32'hC0DE_0011;
        tick();
        req_valid = '0;
        tick();
        check("op11_ctrl", 128'(ctrl), 128'h80);
        check("op11_wdata", 128'(wdata[127:96]), 128'hC0DE_0011);

        // Full: all threads write every cycle, each thread drains at half rate
        do_reset();
        req_valid = 4'b1111;
        req_op    = 8'b10_10_10_10;
        req_data  = {32'h3000_0003, 32'h3000_0002, 32'h3000_0001, 32'h3000_0000};
        tick();
        check("full_e1_ctrl", 128'(ctrl), 128'h0);
        tick();
        check("full_e2_ctrl", 128'(ctrl), 128'h0A);
        tick();
        check("full_e3_ctrl", 128'(ctrl), 128'hA0);
        tick();
        tick();
        check("full_e5_ready", 128'(req_ready), 128'hF);
        tick();
        check("full_e6_ready", 128'(req_ready), 128'h3);
        check("full_e6_ctrl", 128'(ctrl), 128'h0A);
        tick();
        check("full_e7_ready", 128'(req_ready), 128'hC);
        check("full_e7_ctrl", 128'(ctrl), 128'hA0);
        tick();
        check("full_e8_ready", 128'(req_ready), 128'h3);
        tick();
        check("full_e9_ready", 128'(req_ready), 128'hC);
        check("full_e9_ctrl", 128'(ctrl), 128'hA0);
`ifdef ARASHI_INGRESS_STAT_EN
        check("stall_cnt", 128'(stall_cnt), 128'h0002_0002_0001_0001);
`endif

        // Reset in the middle of a burst
        req_valid = '0;
        rstn      = 1'b0;
        #1;
        check("mid_rst_ctrl", 128'(ctrl), 128'h0);
        check("mid_rst_ready", 128'(req_ready), 128'h0);
        check("mid_rst_wdata", wdata, 128'h0);
`ifdef ARASHI_INGRESS_STAT_EN
        check("mid_rst_stall", 128'(stall_cnt), 128'h0);
`endif
        tick();
        rstn = 1'b1;
        #1;
        check("post_rst_ready", 128'(req_ready), 128'hF);
        tick();
        check("post_rst_ctrl1", 128'(ctrl), 128'h0);
        tick();
        check("post_rst_ctrl2", 128'(ctrl), 128'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
